quad_velocity_sampler: RTL
==========================

# quad_velocity_sampler

Quadrature encoder receiver for the Encoder design. It synchronizes the raw A/B channels and decodes them at x4 resolution into a free-running signed position. It also accumulates signed edge counts over a sampling window. The window boundary is the single-cycle periodic `sample_tick` from the sampling-tick generator (3.2 ms at 50 MHz). On each tick the window count is latched as `velocity` and the window restarts.

## Interface
Parameters:
- `CNT_W`, 16: width of the signed window counter and `velocity`.
- `POS_W`, 32: width of the signed position accumulator.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `sample_tick`  in  1  one-cycle window-boundary pulse, synchronous to `clk`.
- `enc_a`  in  1  encoder channel A, asynchronous.
- `enc_b`  in  1  encoder channel B, asynchronous.
- `position`  out  POS_W  signed position, two's complement.
- `velocity`  out  CNT_W  signed edge count of the last completed window.
- `vel_valid`  out  1  one-cycle pulse; `velocity` has just been updated.
- `dir`  out  1  direction of the last legal edge (1 = forward).
- `err_cnt`  out  8  saturating count of illegal transitions.

## Operation
- **Synchronizer.** Each channel passes through a 2-flop synchronizer (`s1`, `s2`). The decoder compares `s2` = {A,B} against the registered previous state `prev`.
- **Priming after reset.**
  - A 2-bit prime counter runs for 3 cycles after reset deassertion.
  - While priming, `prev <= s2` every cycle and no decode occurs.
  - This prevents a spurious count when the encoder rests at a non-zero state.
- **Decode**, once primed. The forward sequence is 00→01→11→10→00.
  - Forward step: delta = +1, `dir` <= 1.
  - Reverse step: delta = −1, `dir` <= 0.
  - No change: delta = 0.
  - Both bits changed (illegal): delta = 0, `err_cnt` increments and saturates at 255. `dir` is unchanged.
  - `prev <= s2` every cycle, including illegal cycles.
- **Position.** `position <= position + delta` every cycle. It wraps modulo 2^POS_W with no saturation.
- **Window counter** (`win`, signed CNT_W):
  - `win + delta` saturates at +(2^(CNT_W−1)−1) and −2^(CNT_W−1). It never wraps.
  - When `sample_tick` = 1: `velocity <= sat(win + delta)`, `win <= 0`, `vel_valid <= 1`. An edge decoded in the tick cycle belongs to the closing window.
  - When `sample_tick` = 0: `win <= sat(win + delta)`, `vel_valid <= 0`.
- **Back-to-back ticks.** Each tick closes a window. A tick immediately after another latches the edges seen in that single cycle, possibly 0.
- **Reset values** (async, immediate on `rst` high):
  - `position` = 0, `velocity` = 0, `vel_valid` = 0, `dir` = 1, `err_cnt` = 0.
  - `win` = 0, `s1` = `s2` = `prev` = 00, prime counter = 0.
- **Reset mid-window.** The partial window is discarded. No `vel_valid` is produced for it.

## Timing
- **Pin-to-output latency.** If an input change is captured by `s1` at edge k, it reaches `s2` at edge k+1. `position`, `dir`, `err_cnt` and `win` update at edge k+2.
- **Tick latency.** `sample_tick` high during the cycle ending at edge t produces `velocity` and `vel_valid` = 1 after edge t. `vel_valid` drops after edge t+1 unless another tick occurred.
- **Edge rate.** The decoder is correct for at most one state change per channel per 2 clocks. Faster input is outside the spec and may count as illegal.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Forward run.** Release reset with A/B = 11 (must not count). Drive 40 forward steps, each held 10 clk. Apply `sample_tick` after the last edge plus 5 clk. Required: `position` = 40, `velocity` = 40, `vel_valid` high exactly 1 cycle, `dir` = 1, `err_cnt` = 0.
- **Reverse with mid-window tick.** From reset, drive 10 reverse steps, a tick, then 7 reverse steps, then a tick. Required: `velocity` = −10, then −7; `position` = −17; `dir` = 0.
- **Tick coincident with edge.** Time a forward edge so its decode cycle equals the tick cycle. Required: the edge is counted in the closing window's `velocity`, and the next window starts at 0.
- **Illegal transitions.** Drive 00→11 three times, interleaved with legal steps. Required: `err_cnt` = 3, `position` changes only by the legal steps. After 300 illegal steps, `err_cnt` = 255.
- **Saturation and wrap** (`CNT_W` = 4, `POS_W` = 4). Drive 20 forward steps in one window. Required: `velocity` = 7, `position` = 4 (20 mod 16).
- **Reset mid-window.** Drive 5 steps, assert `rst` asynchronously between clock edges, then release. Required: all outputs are at reset values immediately, no `vel_valid` occurs, and the next window counts from 0.

Source files
------------

// File: rtl/quad_velocity_sampler.sv
// rtl/quad_velocity_sampler.sv - x4 quadrature decoder with position accumulator and windowed velocity
module quad_velocity_sampler #(
   parameter int CNT_W = 16,
   parameter int POS_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sample_tick,
   input  logic                    enc_a,
   input  logic                    enc_b,
   output logic signed [POS_W-1:0] position,
   output logic signed [CNT_W-1:0] velocity,
   output logic                    vel_valid,
   output logic                    dir,
   output logic [7:0]              err_cnt
);

   localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);
   localparam logic signed [CNT_W-1:0] WIN_ONE = CNT_W'(1);
   localparam logic signed [CNT_W-1:0] WIN_MAX = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic signed [CNT_W-1:0] WIN_MIN = {1'b1, {(CNT_W-1){1'b0}}};

   logic [1:0]              s1_q, s1_d;
   logic [1:0]              s2_q, s2_d;
   logic [1:0]              prev_q, prev_d;
   logic [1:0]              prime_q, prime_d;
   logic signed [POS_W-1:0] position_q, position_d;
   logic signed [CNT_W-1:0] win_q, win_d;
   logic signed [CNT_W-1:0] velocity_q, velocity_d;
   logic                    vel_valid_q, vel_valid_d;
   logic                    dir_q, dir_d;
   logic [7:0]              err_cnt_q, err_cnt_d;

   logic                    primed;
   logic                    step_fwd;
   logic                    step_rev;
   logic                    step_ill;
   logic signed [CNT_W-1:0] win_sum;

   // Classify the {prev, s2} transition; nothing is decoded until the prime counter has run out
   always_comb begin
      step_fwd = 1'b0;
      step_rev = 1'b0;
      step_ill = 1'b0;
      primed   = (prime_q == 2'd3);
      case ({prev_q, s2_q})
         4'b0001, 4'b0111, 4'b1110, 4'b1000: step_fwd = 1'b1;
         4'b0010, 4'b1011, 4'b1101, 4'b0100: step_rev = 1'b1;
         4'b0011, 4'b1100, 4'b0110, 4'b1001: step_ill = 1'b1;
         default: ;
      endcase
      if (!primed) begin
         step_fwd = 1'b0;
         step_rev = 1'b0;
         step_ill = 1'b0;
      end
   end

   // Next-state logic: synchronizer, priming, position, saturating window and tick latch
   always_comb begin
      s1_d    = {enc_a, enc_b};
      s2_d    = s1_q;
      prev_d  = s2_q;
      prime_d = primed ? prime_q : prime_q + 2'd1;

      position_d = position_q;
      win_sum    = win_q;
      dir_d      = dir_q;
      err_cnt_d  = err_cnt_q;

      if (step_fwd) begin
         position_d = position_q + POS_ONE;
         win_sum    = (win_q == WIN_MAX) ? win_q : win_q + WIN_ONE;
         dir_d      = 1'b1;
      end else if (step_rev) begin
         position_d = position_q - POS_ONE;
         win_sum    = (win_q == WIN_MIN) ? win_q : win_q - WIN_ONE;
         dir_d      = 1'b0;
      end else if (step_ill && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end

      // An edge decoded in the tick cycle is folded into the window being closed
      if (sample_tick) begin
         velocity_d  = win_sum;
         win_d       = '0;
         vel_valid_d = 1'b1;
      end else begin
         velocity_d  = velocity_q;
         win_d       = win_sum;
         vel_valid_d = 1'b0;
      end
   end

   // State registers; reset discards any partial window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q        <= 2'b00;
         s2_q        <= 2'b00;
         prev_q      <= 2'b00;
         prime_q     <= 2'd0;
         position_q  <= '0;
         win_q       <= '0;
         velocity_q  <= '0;
         vel_valid_q <= 1'b0;
         dir_q       <= 1'b1;
         err_cnt_q   <= 8'd0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         prev_q      <= prev_d;
         prime_q     <= prime_d;
         position_q  <= position_d;
         win_q       <= win_d;
         velocity_q  <= velocity_d;
         vel_valid_q <= vel_valid_d;
         dir_q       <= dir_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign position  = position_q;
   assign velocity  = velocity_q;
   assign vel_valid = vel_valid_q;
   assign dir       = dir_q;
   assign err_cnt   = err_cnt_q;

endmodule
